instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 64'h0, the fetch address loaded on reset.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 3, the number of cycles an address is held before Data is sampled; legal range 1..15.
REQ-003 SHALL provide parameter FILL_WORD, default 32'hABCDDCBA, the unmapped-location pattern returned by instruction memory.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 Reset_L  input  1  asynchronous active-low reset.
REQ-006 Address  output  64  fetch address to instruction memory.
REQ-007 Data  input  32  instruction word returned by instruction memory.
REQ-008 Instr  output  32  captured instruction to decode.
REQ-009 InstrPC  output  64  address Instr was fetched from.
REQ-010 InstrValid  output  1  Instr/InstrPC valid.
REQ-011 InstrReady  input  1  decode accepts Instr.
REQ-012 Redirect  input  1  branch/jump taken; load RedirectPC.
REQ-013 RedirectPC  input  64  redirect target.
REQ-014 Halted  output  1  FILL_WORD fetched; fetching stopped.
REQ-015 FetchCount  output  32  count of accepted instructions.

Function
REQ-016 States SHALL be WAIT, VALID and HALT.
REQ-017 Address SHALL be a register equal to the current PC at all times, never driven combinationally from inputs.
REQ-018 WAIT: 4-bit counter cnt SHALL increment each cycle; on the cycle cnt==WAIT_CYCLES-1, Data SHALL be sampled.
REQ-019 WAIT sample with Data!=FILL_WORD: Instr<=Data, InstrPC<=PC, InstrValid<=1, state<=VALID.
REQ-020 WAIT sample with Data==FILL_WORD: Halted<=1, InstrValid stays 0, state<=HALT.
REQ-021 Latency from Address change to InstrValid high SHALL be exactly WAIT_CYCLES cycles.
REQ-022 VALID: Instr, InstrPC and InstrValid SHALL hold stable while InstrReady==0.
REQ-023 VALID with InstrReady==1 (handshake): PC<=PC+4, FetchCount<=FetchCount+1, InstrValid<=0, cnt<=0, state<=WAIT.
REQ-024 Sustained throughput with InstrReady tied high SHALL be one instruction per WAIT_CYCLES+1 cycles.
REQ-025 HALT: all outputs SHALL hold; only Redirect or reset leaves HALT.
REQ-026 Redirect SHALL take priority in every state: PC<={RedirectPC[63:2],2'b00}, cnt<=0, InstrValid<=0, Halted<=0, state<=WAIT.
REQ-027 Redirect coincident with a VALID handshake: FetchCount SHALL increment; PC SHALL take the redirect target, not PC+4.
REQ-028 Redirect during WAIT SHALL discard the in-flight fetch; no stale Data is ever presented.
REQ-029 PC+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 64'h0); FetchCount SHALL wrap modulo 2^32.
REQ-030 InstrReady SHALL be ignored outside VALID.

Reset
REQ-031 Reset_L low SHALL asynchronously set PC/Address=RESET_PC, state=WAIT, cnt=0, Instr=0, InstrPC=0, InstrValid=0, Halted=0, FetchCount=0.
REQ-032 After Reset_L rises, the first InstrValid SHALL occur WAIT_CYCLES rising edges later.
REQ-033 Reset asserted mid-WAIT or in VALID SHALL abandon the fetch with no handshake counted.

Verification
REQ-034 Reset release, memory model word 0x000=F84003E9, InstrReady=1 -> InstrValid at edge 3, Instr=F84003E9, InstrPC=0; next fetch Address=0x004 yields F84083EA.
REQ-035 InstrReady=1 from 0x000 through 0x02C -> twelve instructions in order ending 0xF80203ED; FetchCount=12; spacing 4 cycles each.
REQ-036 InstrReady held 0 for 10 cycles at 0x008 -> Instr=F84103EB and Address=0x008 stable; raising InstrReady advances Address to 0x00C next cycle.
REQ-037 Redirect=1, RedirectPC=0x037 during WAIT -> Address=0x034, InstrValid low, then Instr=D2E24689 with InstrPC=0x034 after 3 cycles.
REQ-038 Fetch reaching 0x058 (returns ABCDDCBA) -> Halted=1, InstrValid=0, Address frozen; Redirect to 0x000 clears Halted and refetches F84003E9.
REQ-039 Reset_L pulsed low mid-WAIT at 0x040 -> immediate Address=0, InstrValid=0, FetchCount=0; restart per REQ-032.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Brief    : Fixed-latency instruction fetch with valid/ready hand-off to
//             decode, redirect support and halt on the unmapped fill pattern.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int unsigned WAIT_CYCLES = 3,
   parameter logic [31:0] FILL_WORD   = 32'hABCDDCBA
) (
   input  logic        CLK,
   input  logic        Reset_L,
   output logic [63:0] Address,
   input  logic [31:0] Data,
   output logic [31:0] Instr,
   output logic [63:0] InstrPC,
   output logic        InstrValid,
   input  logic        InstrReady,
   input  logic        Redirect,
   input  logic [63:0] RedirectPC,
   output logic        Halted,
   output logic [31:0] FetchCount
);

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_VALID = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [3:0] c_last_cnt = 4'(WAIT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt;
   logic [63:0] r_pc;
   logic [63:0] w_pc;
   logic [31:0] r_instr;
   logic [31:0] w_instr;
   logic [63:0] r_instr_pc;
   logic [63:0] w_instr_pc;
   logic        r_valid;
   logic        w_valid;
   logic        r_halted;
   logic        w_halted;
   logic [31:0] r_fetch_count;
   logic [31:0] w_fetch_count;
   logic        w_handshake;

   // Redirect targets are word aligned; the low address bits are dropped.
   logic        w_unused_redirect_lsbs;
   assign w_unused_redirect_lsbs = ^RedirectPC[1:0];

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         r_state <= ST_WAIT;
      end else begin
         r_state <= w_state;
      end
   end

   always_comb begin
      w_state       = r_state;
      w_cnt         = r_cnt;
      w_pc          = r_pc;
      w_instr       = r_instr;
      w_instr_pc    = r_instr_pc;
      w_valid       = r_valid;
      w_halted      = r_halted;
      w_fetch_count = r_fetch_count;
      w_handshake   = (r_state == ST_VALID) && InstrReady;

      // A handshake is counted even when a redirect lands on the same cycle.
      if (w_handshake) begin
         w_fetch_count = r_fetch_count + 32'd1;
      end

      if (Redirect) begin
         w_pc     = {RedirectPC[63:2], 2'b00};
         w_cnt    = 4'd0;
         w_valid  = 1'b0;
         w_halted = 1'b0;
         w_state  = ST_WAIT;
      end else begin
         case (r_state)
            ST_WAIT: begin
               w_cnt = r_cnt + 4'd1;
               if (r_cnt == c_last_cnt) begin
                  if (Data == FILL_WORD) begin
                     w_halted = 1'b1;
                     w_state  = ST_HALT;
                  end else begin
                     w_instr    = Data;
                     w_instr_pc = r_pc;
                     w_valid    = 1'b1;
                     w_state    = ST_VALID;
                  end
               end
            end
            ST_VALID: begin
               if (InstrReady) begin
                  w_pc    = r_pc + 64'd4;
                  w_cnt   = 4'd0;
                  w_valid = 1'b0;
                  w_state = ST_WAIT;
               end
            end
            ST_HALT: begin
               w_state = ST_HALT;
            end
            default: begin
               w_state = ST_WAIT;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         r_cnt         <= 4'd0;
         r_pc          <= RESET_PC;
         r_instr       <= 32'd0;
         r_instr_pc    <= 64'd0;
         r_valid       <= 1'b0;
         r_halted      <= 1'b0;
         r_fetch_count <= 32'd0;
      end else begin
         r_cnt         <= w_cnt;
         r_pc          <= w_pc;
         r_instr       <= w_instr;
         r_instr_pc    <= w_instr_pc;
         r_valid       <= w_valid;
         r_halted      <= w_halted;
         r_fetch_count <= w_fetch_count;
      end
   end

   assign Address    = r_pc;
   assign Instr      = r_instr;
   assign InstrPC    = r_instr_pc;
   assign InstrValid = r_valid;
   assign Halted     = r_halted;
   assign FetchCount = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Brief    : Directed bench for instr_fetch_unit with a small instruction ROM
//             and an expected-fetch queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam logic [31:0] c_fill = 32'hABCDDCBA;
   localparam logic [31:0] ROM [23] = '{
      32'hF84003E9, 32'hF84083EA, 32'hF84103EB, 32'h8B020020,
      32'h8B030041, 32'hCB040062, 32'hAA050083, 32'h8A0600A4,
      32'hF84203EE, 32'hF84283EF, 32'hB40000C5, 32'hF80203ED,
      32'h91000421, 32'hD2E24689, 32'hF9400021, 32'hF9000022,
      32'h8B010042, 32'hCB020063, 32'h17FFFFF0, 32'hD65F03C0,
      32'hAA1F03E0, 32'hD503201F, 32'hABCDDCBA
   };
   localparam logic [63:0] c_top_word = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        CLK;
   logic        Reset_L;
   logic [63:0] Address;
   logic [31:0] Data;
   logic [31:0] Instr;
   logic [63:0] InstrPC;
   logic        InstrValid;
   logic        InstrReady;
   logic        Redirect;
   logic [63:0] RedirectPC;
   logic        Halted;
   logic [31:0] FetchCount;

   int checks = 0;
   int errors = 0;
   logic [95:0] sb[$];

   instr_fetch_unit dut (
      .CLK        (CLK),
      .Reset_L    (Reset_L),
      .Address    (Address),
      .Data       (Data),
      .Instr      (Instr),
      .InstrPC    (InstrPC),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .Redirect   (Redirect),
      .RedirectPC (RedirectPC),
      .Halted     (Halted),
      .FetchCount (FetchCount)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      int idx;
      if (a == c_top_word) return 32'hD503201F;
      if (a[63:2] < 62'd23) begin
         idx = int'(a[6:2]);
         return ROM[idx];
      end
      return c_fill;
   endfunction

   assign Data = mem_word(Address);

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [63:0] a);
      sb.push_back({a, mem_word(a)});
   endtask

   // Waits for the next presented instruction and checks it against the queue head.
   task automatic expect_fetch(input string tag, input int exp_lat);
      int n;
      logic [95:0] e;
      n = 0;
      do begin
         tick();
         n++;
      end while (!InstrValid && n < 40);
      chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
      if (sb.size() > 0) e = sb.pop_front();
      else e = 'x;
      chk({tag, "_valid"}, 64'(InstrValid), 64'd1);
      chk({tag, "_instr"}, 64'(Instr), 64'(e[31:0]));
      chk({tag, "_pc"}, InstrPC, e[95:32]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      Reset_L    = 1'b0;
      InstrReady = 1'b1;
      Redirect   = 1'b0;
      RedirectPC = 64'd0;
      repeat (2) tick();
      chk("rst_addr", Address, 64'd0);
      chk("rst_valid", 64'(InstrValid), 64'd0);
      chk("rst_halted", 64'(Halted), 64'd0);
      chk("rst_fcount", 64'(FetchCount), 64'd0);
      chk("rst_instr", 64'(Instr), 64'd0);
      chk("rst_instrpc", InstrPC, 64'd0);
      Reset_L = 1'b1;

      push_exp(64'h000);
      expect_fetch("f000", 3);
      push_exp(64'h004);
      expect_fetch("f004", 4);
      chk("addr_004", Address, 64'h004);

      tick();
      InstrReady = 1'b0;
      push_exp(64'h008);
      expect_fetch("f008", 3);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_instr", 64'(Instr), 64'hF84103EB);
         chk("stall_addr", Address, 64'h008);
         chk("stall_valid", 64'(InstrValid), 64'd1);
      end
      InstrReady = 1'b1;
      tick();
      chk("adv_addr", Address, 64'h00C);
      chk("adv_valid", 64'(InstrValid), 64'd0);
      chk("adv_fcount", 64'(FetchCount), 64'd3);

      push_exp(64'h00C);
      expect_fetch("f00c", 3);
      for (int a = 16; a <= 44; a += 4) begin
         push_exp(64'(a));
         expect_fetch("seq", 4);
      end
      chk("last_seq_instr", 64'(Instr), 64'hF80203ED);
      tick();
      chk("seq_fcount", 64'(FetchCount), 64'd12);
      chk("seq_addr", Address, 64'h030);

      tick();
      Redirect   = 1'b1;
      RedirectPC = 64'h037;
      tick();
      Redirect   = 1'b0;
      chk("redir_addr", Address, 64'h034);
      chk("redir_valid", 64'(InstrValid), 64'd0);
      chk("redir_fcount", 64'(FetchCount), 64'd12);
      push_exp(64'h034);
      expect_fetch("redir_f034", 3);
      push_exp(64'h038);
      expect_fetch("f038", 4);
      push_exp(64'h03C);
      expect_fetch("f03c", 4);
      tick();
      chk("pre_rst_addr", Address, 64'h040);
      tick();

      Reset_L = 1'b0;
      #1;
      chk("midrst_addr", Address, 64'd0);
      chk("midrst_valid", 64'(InstrValid), 64'd0);
      chk("midrst_fcount", 64'(FetchCount), 64'd0);
      tick();
      Reset_L = 1'b1;
      push_exp(64'h000);
      expect_fetch("rst_f000", 3);

      Redirect   = 1'b1;
      RedirectPC = 64'h050;
      tick();
      Redirect   = 1'b0;
      chk("coinc_fcount", 64'(FetchCount), 64'd1);
      chk("coinc_addr", Address, 64'h050);
      push_exp(64'h050);
      expect_fetch("f050", 3);
      push_exp(64'h054);
      expect_fetch("f054", 4);
      tick();
      chk("halt_addr", Address, 64'h058);
      n = 0;
      do begin
         tick();
         n++;
      end while (!Halted && n < 20);
      chk("halt_lat", 64'(n), 64'd3);
      chk("halt_valid", 64'(InstrValid), 64'd0);
      repeat (5) tick();
      chk("halt_hold_addr", Address, 64'h058);
      chk("halt_hold_halted", 64'(Halted), 64'd1);
      chk("halt_hold_fcount", 64'(FetchCount), 64'd3);
      chk("halt_hold_valid", 64'(InstrValid), 64'd0);

      Redirect   = 1'b1;
      RedirectPC = 64'h000;
      tick();
      Redirect   = 1'b0;
      chk("unhalt_halted", 64'(Halted), 64'd0);
      chk("unhalt_addr", Address, 64'h000);
      push_exp(64'h000);
      expect_fetch("unhalt_f000", 3);

      Redirect   = 1'b1;
      RedirectPC = 64'hFFFF_FFFF_FFFF_FFFE;
      tick();
      Redirect   = 1'b0;
      chk("top_fcount", 64'(FetchCount), 64'd4);
      chk("top_addr", Address, c_top_word);
      push_exp(c_top_word);
      expect_fetch("ftop", 3);
      tick();
      chk("wrap_addr", Address, 64'd0);
      chk("wrap_fcount", 64'(FetchCount), 64'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
